// File: rtl/micro_sequencer.sv
// Microprogram sequencer: holds the control address register (CAR) and the
// single-level subroutine register (SBR), selects the next microprogram address
// and decodes the F1/F2/F3 fields of the current microinstruction into one-hot
// micro-operation strobes.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), synchronous active-high reset
//   i_en                  advance enable; low stalls CAR/SBR and zeroes strobes
//   i_uinstr              microinstruction read from ROM at o_uaddr
//   i_opcode              instruction opcode used by the MAP branch
//   i_i_bit, i_ac_sign,
//   i_ac_zero             branch condition inputs
//   o_uaddr               ROM address (equals CAR)
//   o_add .. o_write      F1 strobes (codes 1..7)
//   o_sub .. o_pctdr      F2 strobes (codes 1..7)
//   o_xor .. o_artpc      F3 strobes (codes 1..6, code 7 reserved)
//   o_alu_conflict        more than one ALU-select strobe asserted
module micro_sequencer #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned OPC_W  = 4,
    parameter int unsigned UI_W   = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [UI_W-1:0]   i_uinstr,
    input  logic [OPC_W-1:0]  i_opcode,
    input  logic              i_i_bit,
    input  logic              i_ac_sign,
    input  logic              i_ac_zero,
    output logic [ADDR_W-1:0] o_uaddr,
    output logic              o_add,
    output logic              o_clrac,
    output logic              o_incac,
    output logic              o_drtac,
    output logic              o_drtar,
    output logic              o_pctar,
    output logic              o_write,
    output logic              o_sub,
    output logic              o_or,
    output logic              o_and,
    output logic              o_read,
    output logic              o_actdr,
    output logic              o_incdr,
    output logic              o_pctdr,
    output logic              o_xor,
    output logic              o_com,
    output logic              o_shl,
    output logic              o_shr,
    output logic              o_incpc,
    output logic              o_artpc,
    output logic              o_alu_conflict
);

    typedef enum logic [1:0] {
        BrJmp  = 2'b00,
        BrCall = 2'b01,
        BrRet  = 2'b10,
        BrMap  = 2'b11
    } br_e;

    logic [ADDR_W-1:0] r_car;
    logic [ADDR_W-1:0] r_sbr;

    logic [2:0]        w_f1;
    logic [2:0]        w_f2;
    logic [2:0]        w_f3;
    logic [1:0]        w_cd;
    br_e               w_br;
    logic [ADDR_W-1:0] w_ad;
    logic              w_u;
    logic              w_active;
    logic [ADDR_W-1:0] w_car_inc;
    logic [ADDR_W-1:0] w_car_d;
    logic [ADDR_W-1:0] w_sbr_d;
    logic [8:0]        w_alu;

    assign w_f1 = i_uinstr[19:17];
    assign w_f2 = i_uinstr[16:14];
    assign w_f3 = i_uinstr[13:11];
    assign w_cd = i_uinstr[10:9];
    assign w_br = br_e'(i_uinstr[8:7]);
    assign w_ad = i_uinstr[ADDR_W-1:0];

    assign w_active  = i_en & ~i_rst;
    // Natural wrap at 2^ADDR_W; SBR captures the wrapped value on CALL.
    assign w_car_inc = r_car + ADDR_W'(1);
    assign o_uaddr   = r_car;

    always_comb begin
        w_u = 1'b1;
        unique case (w_cd)
            2'b00: w_u = 1'b1;
            2'b01: w_u = i_i_bit;
            2'b10: w_u = i_ac_sign;
            2'b11: w_u = i_ac_zero;
            default: w_u = 1'b1;
        endcase
    end

    always_comb begin
        w_car_d = w_car_inc;
        w_sbr_d = r_sbr;
        unique case (w_br)
            BrJmp: begin
                if (w_u) w_car_d = w_ad;
            end
            BrCall: begin
                if (w_u) begin
                    w_sbr_d = w_car_inc;
                    w_car_d = w_ad;
                end
            end
            BrRet: w_car_d = r_sbr;
            BrMap: w_car_d = {1'b0, i_opcode, 2'b00};
            default: w_car_d = w_car_inc;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_car <= '0;
            r_sbr <= '0;
        end else if (i_en) begin
            r_car <= w_car_d;
            r_sbr <= w_sbr_d;
        end
    end

    // Field decode: code 000 asserts nothing, F3 code 111 is reserved.
    always_comb begin
        o_add   = 1'b0;
        o_clrac = 1'b0;
        o_incac = 1'b0;
        o_drtac = 1'b0;
        o_drtar = 1'b0;
        o_pctar = 1'b0;
        o_write = 1'b0;
        o_sub   = 1'b0;
        o_or    = 1'b0;
        o_and   = 1'b0;
        o_read  = 1'b0;
        o_actdr = 1'b0;
        o_incdr = 1'b0;
        o_pctdr = 1'b0;
        o_xor   = 1'b0;
        o_com   = 1'b0;
        o_shl   = 1'b0;
        o_shr   = 1'b0;
        o_incpc = 1'b0;
        o_artpc = 1'b0;
        if (w_active) begin
            case (w_f1)
                3'd1: o_add   = 1'b1;
                3'd2: o_clrac = 1'b1;
                3'd3: o_incac = 1'b1;
                3'd4: o_drtac = 1'b1;
                3'd5: o_drtar = 1'b1;
                3'd6: o_pctar = 1'b1;
                3'd7: o_write = 1'b1;
                default: ;
            endcase
            case (w_f2)
                3'd1: o_sub   = 1'b1;
                3'd2: o_or    = 1'b1;
                3'd3: o_and   = 1'b1;
                3'd4: o_read  = 1'b1;
                3'd5: o_actdr = 1'b1;
                3'd6: o_incdr = 1'b1;
                3'd7: o_pctdr = 1'b1;
                default: ;
            endcase
            case (w_f3)
                3'd1: o_xor   = 1'b1;
                3'd2: o_com   = 1'b1;
                3'd3: o_shl   = 1'b1;
                3'd4: o_shr   = 1'b1;
                3'd5: o_incpc = 1'b1;
                3'd6: o_artpc = 1'b1;
                default: ;
            endcase
        end
    end

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign w_alu = {o_add, o_drtac, o_sub, o_or, o_and, o_xor, o_com, o_shl, o_shr};
    assign o_alu_conflict = (w_alu & (w_alu - 9'd1)) != 9'd0;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: a CAR/SBR reference model produces
// the expected address/strobes for each cycle into a scoreboard queue, which is
// popped and compared against the DUT mid-cycle.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        d_rst;
    logic        d_en;
    logic [19:0] d_uinstr;
    logic [3:0]  d_opcode;
    logic        d_i_bit;
    logic        d_ac_sign;
    logic        d_ac_zero;

    logic [6:0]  o_uaddr;
    logic        o_add, o_clrac, o_incac, o_drtac, o_drtar, o_pctar, o_write;
    logic        o_sub, o_or, o_and, o_read, o_actdr, o_incdr, o_pctdr;
    logic        o_xor, o_com, o_shl, o_shr, o_incpc, o_artpc;
    logic        o_alu_conflict;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [6:0]  uaddr;
        logic [19:0] strb;
        logic        conf;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    logic [6:0] m_car;
    logic [6:0] m_sbr;

    always #5 clk = ~clk;

    micro_sequencer #(
        .ADDR_W(7),
        .OPC_W (4),
        .UI_W  (20)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (d_rst),
        .i_en          (d_en),
        .i_uinstr      (d_uinstr),
        .i_opcode      (d_opcode),
        .i_i_bit       (d_i_bit),
        .i_ac_sign     (d_ac_sign),
        .i_ac_zero     (d_ac_zero),
        .o_uaddr       (o_uaddr),
        .o_add         (o_add),
        .o_clrac       (o_clrac),
        .o_incac       (o_incac),
        .o_drtac       (o_drtac),
        .o_drtar       (o_drtar),
        .o_pctar       (o_pctar),
        .o_write       (o_write),
        .o_sub         (o_sub),
        .o_or          (o_or),
        .o_and         (o_and),
        .o_read        (o_read),
        .o_actdr       (o_actdr),
        .o_incdr       (o_incdr),
        .o_pctdr       (o_pctdr),
        .o_xor         (o_xor),
        .o_com         (o_com),
        .o_shl         (o_shl),
        .o_shr         (o_shr),
        .o_incpc       (o_incpc),
        .o_artpc       (o_artpc),
        .o_alu_conflict(o_alu_conflict)
    );

    logic [19:0] w_strb;
    assign w_strb = {o_add, o_clrac, o_incac, o_drtac, o_drtar, o_pctar, o_write,
                     o_sub, o_or, o_and, o_read, o_actdr, o_incdr, o_pctdr,
                     o_xor, o_com, o_shl, o_shr, o_incpc, o_artpc};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] mk(input logic [2:0] f1, input logic [2:0] f2,
                                       input logic [2:0] f3, input logic [1:0] cd,
                                       input logic [1:0] br, input logic [6:0] ad);
        return {f1, f2, f3, cd, br, ad};
    endfunction

    // Expected strobe vector in the same order as w_strb.
    function automatic logic [19:0] exp_strb(input logic [19:0] ui, input logic act);
        logic [6:0] g1, g2;
        logic [5:0] g3;
        logic [2:0] f1, f2, f3;
        f1 = ui[19:17];
        f2 = ui[16:14];
        f3 = ui[13:11];
        g1 = (f1 == 3'd0) ? 7'd0 : (7'b1000000 >> (f1 - 3'd1));
        g2 = (f2 == 3'd0) ? 7'd0 : (7'b1000000 >> (f2 - 3'd1));
        g3 = (f3 == 3'd0 || f3 == 3'd7) ? 6'd0 : (6'b100000 >> (f3 - 3'd1));
        return act ? {g1, g2, g3} : 20'd0;
    endfunction

    function automatic logic exp_conf(input logic [19:0] s);
        int n;
        n = 0;
        // ALU selects: ADD, DRTAC, SUB, OR, AND, XOR, COM, SHL, SHR
        if (s[19]) n++;
        if (s[16]) n++;
        if (s[12]) n++;
        if (s[11]) n++;
        if (s[10]) n++;
        if (s[5])  n++;
        if (s[4])  n++;
        if (s[3])  n++;
        if (s[2])  n++;
        return n > 1;
    endfunction

    // Drive one cycle, score it mid-cycle, then advance the model on the edge.
    task automatic step(input string tag, input logic [19:0] ui, input logic en,
                        input logic rst);
        exp_t  e;
        string t;
        logic  u;
        logic [6:0] inc;
        d_uinstr = ui;
        d_en     = en;
        d_rst    = rst;
        e.uaddr  = m_car;
        e.strb   = exp_strb(ui, en & ~rst);
        e.conf   = exp_conf(e.strb);
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check_eq({t, "_uaddr"}, 32'(o_uaddr), 32'(e.uaddr));
        check_eq({t, "_strb"}, 32'(w_strb), 32'(e.strb));
        check_eq({t, "_conf"}, 32'(o_alu_conflict), 32'(e.conf));
        @(posedge clk);
        case (ui[10:9])
            2'b00: u = 1'b1;
            2'b01: u = d_i_bit;
            2'b10: u = d_ac_sign;
            default: u = d_ac_zero;
        endcase
        inc = m_car + 7'd1;
        if (rst) begin
            m_car = 7'd0;
            m_sbr = 7'd0;
        end else if (en) begin
            if (ui[8:7] == 2'b00) m_car = u ? ui[6:0] : inc;
            else if (ui[8:7] == 2'b01) begin
                if (u) begin
                    m_sbr = inc;
                    m_car = ui[6:0];
                end else begin
                    m_car = inc;
                end
            end else if (ui[8:7] == 2'b10) m_car = m_sbr;
            else m_car = {1'b0, d_opcode, 2'b00};
        end
        #1;
    endtask

    task automatic expect_addr(input string tag, input logic [6:0] exp);
        check_eq(tag, 32'(o_uaddr), 32'(exp));
    endtask

    task automatic goto_addr(input logic [6:0] a);
        step("goto", mk(3'd0, 3'd0, 3'd0, 2'd0, 2'd0, a), 1'b1, 1'b0);
    endtask

    logic [19:0] seq_ui;

    initial begin
        d_rst = 1'b1;
        d_en = 1'b0;
        d_uinstr = 20'h0;
        d_opcode = 4'h0;
        d_i_bit = 1'b0;
        d_ac_sign = 1'b0;
        d_ac_zero = 1'b0;
        m_car = 7'd0;
        m_sbr = 7'd0;
        @(posedge clk);
        #1;

        // Reset: strobes forced low even with a live microinstruction.
        step("rst0", 20'h00000, 1'b0, 1'b1);
        step("rst1", mk(3'd1, 3'd1, 3'd1, 2'd0, 2'd0, 7'h55), 1'b1, 1'b1);
        expect_addr("rst_addr", 7'h00);

        // Sequential fetch: CD=01 with i_bit=0 falls through to CAR+1.
        seq_ui = mk(3'd0, 3'd0, 3'd0, 2'd1, 2'd0, 7'h00);
        step("fetch0", seq_ui, 1'b1, 1'b0);
        expect_addr("fetch_1", 7'h01);
        step("fetch1", seq_ui, 1'b1, 1'b0);
        expect_addr("fetch_2", 7'h02);
        step("fetch2", seq_ui, 1'b1, 1'b0);
        expect_addr("fetch_3", 7'h03);

        // Field decode sweeps.
        for (int k = 1; k < 8; k++) step("f1", mk(3'(k), 3'd0, 3'd0, 2'd1, 2'd0, 7'h0), 1'b1, 1'b0);
        for (int k = 1; k < 8; k++) step("f2", mk(3'd0, 3'(k), 3'd0, 2'd1, 2'd0, 7'h0), 1'b1, 1'b0);
        for (int k = 1; k < 8; k++) step("f3", mk(3'd0, 3'd0, 3'(k), 2'd1, 2'd0, 7'h0), 1'b1, 1'b0);
        step("add_sub", mk(3'd1, 3'd1, 3'd0, 2'd1, 2'd0, 7'h0), 1'b1, 1'b0);
        step("drtac_and_shr", mk(3'd4, 3'd3, 3'd4, 2'd1, 2'd0, 7'h0), 1'b1, 1'b0);
        step("pctar_read_incpc", mk(3'd6, 3'd4, 3'd5, 2'd1, 2'd0, 7'h0), 1'b1, 1'b0);

        // Conditional JMP on each condition source, taken and not taken.
        for (int c = 1; c < 4; c++) begin
            for (int v = 1; v >= 0; v--) begin
                goto_addr(7'h10);
                d_i_bit   = (c == 1) ? 1'(v) : ~1'(v);
                d_ac_sign = (c == 2) ? 1'(v) : ~1'(v);
                d_ac_zero = (c == 3) ? 1'(v) : ~1'(v);
                step("cjmp", mk(3'd0, 3'd0, 3'd0, 2'(c), 2'd0, 7'h40), 1'b1, 1'b0);
                expect_addr("cjmp_target", (v == 1) ? 7'h40 : 7'h11);
            end
        end
        d_i_bit = 1'b0;
        d_ac_sign = 1'b0;
        d_ac_zero = 1'b0;

        // CALL / RET, then CALL not taken keeps SBR.
        goto_addr(7'h05);
        step("call", mk(3'd0, 3'd0, 3'd0, 2'd0, 2'd1, 7'h60), 1'b1, 1'b0);
        expect_addr("call_target", 7'h60);
        step("ret", mk(3'd0, 3'd0, 3'd0, 2'd3, 2'd2, 7'h33), 1'b1, 1'b0);
        expect_addr("ret_target", 7'h06);
        step("call_nt", mk(3'd0, 3'd0, 3'd0, 2'd1, 2'd1, 7'h50), 1'b1, 1'b0);
        expect_addr("call_nt_addr", 7'h07);
        step("ret2", mk(3'd0, 3'd0, 3'd0, 2'd0, 2'd2, 7'h00), 1'b1, 1'b0);
        expect_addr("ret_sbr_kept", 7'h06);

        // MAP.
        d_opcode = 4'hA;
        step("map", mk(3'd0, 3'd0, 3'd0, 2'd1, 2'd3, 7'h11), 1'b1, 1'b0);
        expect_addr("map_target", 7'h28);

        // Wrap of CAR+1 and of the SBR return address.
        goto_addr(7'h7F);
        step("wrap", mk(3'd0, 3'd0, 3'd0, 2'd1, 2'd0, 7'h44), 1'b1, 1'b0);
        expect_addr("wrap_addr", 7'h00);
        goto_addr(7'h7F);
        step("call_wrap", mk(3'd0, 3'd0, 3'd0, 2'd0, 2'd1, 7'h30), 1'b1, 1'b0);
        step("ret_wrap", mk(3'd0, 3'd0, 3'd0, 2'd0, 2'd2, 7'h00), 1'b1, 1'b0);
        expect_addr("ret_wrap_addr", 7'h00);

        // Stall at 0x22, then resume with the condition sampled fresh.
        goto_addr(7'h22);
        for (int k = 0; k < 3; k++) begin
            d_ac_sign = ~d_ac_sign;
            step("stall", mk(3'd1, 3'd1, 3'd2, 2'd2, 2'd0, 7'h40), 1'b0, 1'b0);
            expect_addr("stall_hold", 7'h22);
        end
        d_ac_sign = 1'b0;
        step("resume", mk(3'd1, 3'd0, 3'd2, 2'd2, 2'd0, 7'h40), 1'b1, 1'b0);
        expect_addr("resume_addr", 7'h23);

        // Reset wins over enable at CAR=0x22 with a non-zero SBR.
        goto_addr(7'h21);
        step("call_22", mk(3'd0, 3'd0, 3'd0, 2'd0, 2'd1, 7'h22), 1'b1, 1'b0);
        expect_addr("at_22", 7'h22);
        step("rst_en", mk(3'd1, 3'd0, 3'd0, 2'd0, 2'd0, 7'h40), 1'b1, 1'b1);
        expect_addr("rst_en_car", 7'h00);
        step("ret_after_rst", mk(3'd0, 3'd0, 3'd0, 2'd0, 2'd2, 7'h00), 1'b1, 1'b0);
        expect_addr("sbr_cleared", 7'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microprogram control unit: holds the control address register (CAR) and the subroutine register (SBR), and sequences through the external microprogram ROM.
- Decodes the current microinstruction fields F1/F2/F3 into one-hot micro-operation strobes. These include the ALU select lines ADD, DRTAC, SUB, OR, AND, XOR, COM, SHL and SHR, plus the register-transfer and memory strobes.
- Sits between the microprogram ROM and the datapath. It is the issuing end of the ALU control interface.

Parameters:
- ADDR_W, 7, CAR/SBR/ROM address width. Must equal OPC_W+3.
- OPC_W, 4, instruction opcode width used by the MAP branch.
- UI_W, 20, microinstruction width. Fixed layout: F1[19:17] F2[16:14] F3[13:11] CD[10:9] BR[8:7] AD[6:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  advance enable. Low = stall: CAR/SBR hold and all strobes are 0.
- uinstr  in  UI_W  microinstruction read asynchronously from ROM at uaddr.
- opcode  in  OPC_W  current instruction opcode (IR[14:11]).
- i_bit  in  1  indirect bit (DR[15]).
- ac_sign  in  1  AC[15].
- ac_zero  in  1  AC==0.
- uaddr  out  ADDR_W  equals CAR; drives the ROM address.
- ADD, CLRAC, INCAC, DRTAC, DRTAR, PCTAR, WRITE  out  1 each  F1 strobes, codes 001..111.
- SUB, OR, AND, READ, ACTDR, INCDR, PCTDR  out  1 each  F2 strobes, codes 001..111.
- XOR, COM, SHL, SHR, INCPC, ARTPC  out  1 each  F3 strobes, codes 001..110. Code 111 is reserved and asserts nothing.
- alu_conflict  out  1  more than one ALU-select strobe is asserted this cycle.

Behaviour:
- Reset: on a rising clk edge with rst=1, CAR=0 and SBR=0. While rst=1, all strobes and alu_conflict are forced to 0. uaddr=0 from the first cycle after reset. rst has priority over en.
- Decode is combinational from uinstr and gated by en and !rst. Field code 000 asserts nothing. Each field drives at most one strobe.
- Condition select U by CD:
  - 00 → 1
  - 01 → i_bit
  - 10 → ac_sign
  - 11 → ac_zero
- Next address, applied on a clk edge with en=1, by BR:
  - 00 JMP: CAR = U ? AD : CAR+1.
  - 01 CALL: if U then SBR = CAR+1 and CAR = AD; else CAR = CAR+1 and SBR unchanged.
  - 10 RET: CAR = SBR, unconditional (CD ignored). SBR unchanged.
  - 11 MAP: CAR = {1'b0, opcode, 2'b00}, unconditional.
- CAR+1 is modulo 2^ADDR_W: 127+1 → 0. SBR stores the wrapped value.
- SBR is single-level. A CALL inside a subroutine overwrites it.
- en=0: CAR and SBR hold, strobes are 0, uaddr is stable. Resuming re-executes the same microinstruction with conditions sampled fresh.
- Latency: strobes for address A are valid in the same cycle CAR=A. The next address takes effect one clock later. Every microinstruction occupies exactly one cycle.
- alu_conflict = popcount({ADD, DRTAC, SUB, OR, AND, XOR, COM, SHL, SHR}) > 1. Example: F1=ADD with F2=SUB.
  - Informational only. Strobes are still all driven; the ALU resolves priority.
  - The bench treats any assertion as a microcode error.
- Condition inputs are sampled on the same edge that updates CAR. No internal registering.

Test Plan:
- Reset/fetch: assert rst for 2 cycles with uinstr=0x00000 → uaddr=0, all strobes 0. Deassert rst, en=1 → uaddr steps 0,1,2,3 on successive edges.
- ALU decode: uinstr with F1=001 → ADD=1 only. F1=100 → DRTAC=1 only. F2=001/010/011 → SUB/OR/AND. F3=001..100 → XOR/COM/SHL/SHR. F1=001 with F2=001 → ADD=1, SUB=1, alu_conflict=1.
- Conditional JMP: at CAR=0x10, CD=10, BR=00, AD=0x40. With ac_sign=1 → next uaddr=0x40. With ac_sign=0 → 0x11. Repeat with CD=11/ac_zero and CD=01/i_bit.
- CALL/RET: at CAR=0x05, CD=00, BR=01, AD=0x60 → uaddr=0x60, SBR=0x06. At 0x60, BR=10 → uaddr=0x06. A CALL with U=0 leaves SBR unchanged.
- MAP and wrap: opcode=4'hA with BR=11 → uaddr=0x28. At CAR=0x7F with a JMP whose U=0 → uaddr=0x00.
- Stall/reset mid-run: en=0 for 3 cycles at CAR=0x22 → uaddr holds 0x22 and strobes are 0. rst=1 together with en=1 at CAR=0x22 → CAR=0 and SBR=0 on that edge.
